// File: rtl/wb_mem_pkg.sv
// -----------------------------------------------------------------------------
// wb_mem_pkg
// Shared definitions for the write-back buffer / memory arbiter.
//   DEF_ADDR_W / DEF_DATA_W / DEF_DEPTH : default widths and buffer depth
//   N_WB / N_RD                         : number of write-back and read requesters
//   WB_C0_CPU..WB_C1_BUS                : write-back requester indices
//   wb_entry_t                          : one buffered write {addr, data}
//   state_t                             : arbiter FSM state
// -----------------------------------------------------------------------------
package wb_mem_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 8;

    localparam int N_WB = 4;
    localparam int N_RD = 2;

    // Write-back requester indices; a higher index is younger within a cycle.
    localparam int WB_C0_CPU = 0;
    localparam int WB_C0_BUS = 1;
    localparam int WB_C1_CPU = 2;
    localparam int WB_C1_BUS = 3;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/wb_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_mem_arbiter_if
// Bundles the cache-side and memory-side signals of the arbiter.
//   wb_valid/wb_addr/wb_data : 4 write-back requesters -> arbiter
//   wb_stall                 : arbiter -> requesters, hold write-backs
//   rd_req/rd_addr           : 2 fill-read requesters -> arbiter
//   rd_valid/rd_data         : arbiter -> readers, one-cycle data pulse
//   mem_re/mem_we/mem_addr/mem_wdata : arbiter -> single-port memory
//   mem_rdata                : memory -> arbiter, valid cycle after mem_re
// Handshake: rd_req is a level held until the cycle rd_valid pulses for that
// port and must drop on the following cycle. Write-backs are accepted in any
// cycle where wb_stall is low; while wb_stall is high they are ignored and
// the requester keeps wb_valid asserted.
// Modports: slave = arbiter, master = caches + memory (environment).
// -----------------------------------------------------------------------------
interface wb_mem_arbiter_if #(
    parameter int ADDR_W = wb_mem_pkg::DEF_ADDR_W,
    parameter int DATA_W = wb_mem_pkg::DEF_DATA_W
);
    logic [wb_mem_pkg::N_WB-1:0]             wb_valid;
    logic [wb_mem_pkg::N_WB-1:0][ADDR_W-1:0] wb_addr;
    logic [wb_mem_pkg::N_WB-1:0][DATA_W-1:0] wb_data;
    logic                                    wb_stall;

    logic [wb_mem_pkg::N_RD-1:0]             rd_req;
    logic [wb_mem_pkg::N_RD-1:0][ADDR_W-1:0] rd_addr;
    logic [wb_mem_pkg::N_RD-1:0]             rd_valid;
    logic [DATA_W-1:0]                       rd_data;

    logic                                    mem_re;
    logic                                    mem_we;
    logic [ADDR_W-1:0]                       mem_addr;
    logic [DATA_W-1:0]                       mem_wdata;
    logic [DATA_W-1:0]                       mem_rdata;

    modport slave (
        input  wb_valid, wb_addr, wb_data, rd_req, rd_addr, mem_rdata,
        output wb_stall, rd_valid, rd_data, mem_re, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output wb_valid, wb_addr, wb_data, rd_req, rd_addr, mem_rdata,
        input  wb_stall, rd_valid, rd_data, mem_re, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/wb_fifo4.sv
// -----------------------------------------------------------------------------
// wb_fifo4
// Circular write buffer: up to 4 enqueues per cycle (index order, higher index
// younger), one pop per cycle, plus a youngest-match address lookup over the
// registered entries.
//   clk, reset            : clock, synchronous active-high reset
//   enq_valid_i/addr/data : per-requester enqueue (caller gates with stall)
//   pop_i                 : remove head entry (caller ensures count_o != 0)
//   count_o               : number of buffered entries
//   head_addr_o/data_o    : oldest entry
//   lk_addr_i             : lookup address
//   lk_hit_o/lk_data_o    : match found / data of the youngest match
// -----------------------------------------------------------------------------
module wb_fifo4
    import wb_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N_WB-1:0]                  enq_valid_i,
    input  logic [N_WB-1:0][ADDR_W-1:0]      enq_addr_i,
    input  logic [N_WB-1:0][DATA_W-1:0]      enq_data_i,
    input  logic                             pop_i,
    output logic [$clog2(DEPTH):0]           count_o,
    output logic [ADDR_W-1:0]                head_addr_o,
    output logic [DATA_W-1:0]                head_data_o,
    input  logic [ADDR_W-1:0]                lk_addr_i,
    output logic                             lk_hit_o,
    output logic [DATA_W-1:0]                lk_data_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic [PTR_W-1:0]  slot [N_WB];
    logic [2:0]        n_enq;
    logic [PTR_W-1:0]  lk_idx;

    // Each valid requester takes the next free slot after all lower-indexed
    // valid requesters, so the packing preserves age order.
    always_comb begin
        n_enq = '0;
        for (int k = 0; k < N_WB; k++) begin
            slot[k] = wr_ptr_q + PTR_W'(n_enq);
            n_enq   = n_enq + 3'(enq_valid_i[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int k = 0; k < N_WB; k++) begin
                if (enq_valid_i[k]) begin
                    addr_q[slot[k]] <= enq_addr_i[k];
                    data_q[slot[k]] <= enq_data_i[k];
                end
            end
            wr_ptr_q <= wr_ptr_q + PTR_W'(n_enq);
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop_i);
            count_q  <= count_q + CNT_W'(n_enq) - CNT_W'(pop_i);
        end
    end

    // Walk from oldest to youngest; a later match overrides an earlier one.
    always_comb begin
        lk_hit_o  = 1'b0;
        lk_data_o = '0;
        lk_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            lk_idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (addr_q[lk_idx] == lk_addr_i)) begin
                lk_hit_o  = 1'b1;
                lk_data_o = data_q[lk_idx];
            end
        end
    end

    assign count_o     = count_q;
    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];

endmodule

// File: rtl/wb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// wb_mem_arbiter
// Shares one single-port synchronous memory between four write-back sources
// (buffered) and two fill-read sources (round-robin, with forwarding from the
// write buffer).
//   clk, reset  : clock, synchronous active-high reset
//   bus         : wb_mem_arbiter_if slave modport (caches and memory)
//   dbg_state_o : current FSM state
//   dbg_count_o : write-buffer occupancy
// -----------------------------------------------------------------------------
module wb_mem_arbiter
    import wb_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    wb_mem_arbiter_if.slave        bus,
    output state_t                 dbg_state_o,
    output logic [$clog2(DEPTH):0] dbg_count_o
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_t            state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic              grant_q, grant_d;
    logic [N_RD-1:0]   hit_vld_q, hit_vld_d;
    logic [DATA_W-1:0] hit_data_q, hit_data_d;

    logic [CNT_W-1:0]  count;
    logic              stall;
    logic [N_WB-1:0]   enq_valid;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              lk_hit;
    logic [DATA_W-1:0] lk_data;

    logic [N_RD-1:0]   elig;
    logic              any_req;
    logic              winner;
    logic              rd_go;
    logic              pop;
    logic [N_RD-1:0]   rw_valid;

    // A full burst of four must always fit, so stall above DEPTH-4.
    assign stall     = count > CNT_W'(DEPTH - 4);
    assign enq_valid = bus.wb_valid & {N_WB{~stall}};

    wb_fifo4 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .enq_valid_i (enq_valid),
        .enq_addr_i  (bus.wb_addr),
        .enq_data_i  (bus.wb_data),
        .pop_i       (pop & ~reset),
        .count_o     (count),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .lk_addr_i   (bus.rd_addr[winner]),
        .lk_hit_o    (lk_hit),
        .lk_data_o   (lk_data)
    );

    // A port whose hit data is being delivered this cycle still holds rd_req;
    // it must not be granted again.
    always_comb begin
        elig    = bus.rd_req & ~hit_vld_q;
        any_req = |elig;
        winner  = (elig == 2'b11) ? rr_ptr_q : elig[1];
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        hit_vld_d  = '0;
        hit_data_d = hit_data_q;
        rd_go      = 1'b0;
        pop        = 1'b0;
        rw_valid   = '0;
        case (state_q)
            ST_IDLE: begin
                if (any_req && lk_hit) begin
                    // Forward from the buffer; the memory port stays idle.
                    hit_vld_d[winner] = 1'b1;
                    hit_data_d        = lk_data;
                    rr_ptr_d          = ~winner;
                end else if (any_req && (count != CNT_W'(DEPTH))) begin
                    rd_go    = 1'b1;
                    grant_d  = winner;
                    rr_ptr_d = ~winner;
                    state_d  = ST_RD_WAIT;
                end else if (count != '0) begin
                    // Also covers a full buffer holding off a read miss.
                    pop = 1'b1;
                end
            end
            ST_RD_WAIT: begin
                rw_valid[grant_q] = 1'b1;
                state_d           = ST_IDLE;
                if (count != '0) begin
                    pop = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= 1'b0;
            grant_q    <= 1'b0;
            hit_vld_q  <= '0;
            hit_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            hit_vld_q  <= hit_vld_d;
            hit_data_q <= hit_data_d;
        end
    end

    // Reset masks strobes combinationally so a read in flight never reports.
    assign bus.wb_stall  = stall;
    assign bus.mem_re    = rd_go & ~reset;
    assign bus.mem_we    = pop & ~reset;
    assign bus.mem_addr  = rd_go ? bus.rd_addr[winner] : head_addr;
    assign bus.mem_wdata = head_data;
    assign bus.rd_valid  = reset ? '0 : (hit_vld_q | rw_valid);
    assign bus.rd_data   = (state_q == ST_RD_WAIT) ? bus.mem_rdata : hit_data_q;

    assign dbg_state_o = state_q;
    assign dbg_count_o = count;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_mem_arbiter
// Directed bench for wb_mem_arbiter with a behavioural synchronous memory and
// an expected-write queue checked on every mem_we.
// -----------------------------------------------------------------------------
module tb_wb_mem_arbiter;
    import wb_mem_pkg::*;

    localparam int AW  = DEF_ADDR_W;
    localparam int DW  = DEF_DATA_W;
    localparam int DEP = DEF_DEPTH;
    localparam int CW  = $clog2(DEP) + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
    state_t        dbg_state;
    logic [CW-1:0] dbg_count;

    wb_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state),
        .dbg_count_o (dbg_count)
    );

    // ---------------- memory model ----------------
    logic [DW-1:0] mem_model [2**AW];
    initial begin
        for (int i = 0; i < 2**AW; i++) mem_model[i] <= 32'hC0DE_0000 + DW'(i);
    end
    always @(posedge clk) begin
        if (bus.mem_we) mem_model[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem_model[bus.mem_addr];
    end

    // ---------------- scoreboard ----------------
    int tests_run = 0;
    int fails     = 0;
    int re_cnt    = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] exp_w;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Every memory write must be the next expected {addr, data}.
    always @(posedge clk) begin
        if (bus.mem_re) re_cnt++;
        if (bus.mem_we) begin
            if (exp_q.size() != 0) exp_w = exp_q.pop_front();
            else                   exp_w = '1;
            check("wr_order", 64'({bus.mem_addr, bus.mem_wdata}), 64'(exp_w));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clr_inputs();
        bus.wb_valid = '0;
        bus.rd_req   = '0;
    endtask

    task automatic set_wb(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wb_valid[k] = 1'b1;
        bus.wb_addr[k]  = a;
        bus.wb_data[k]  = d;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        bus.rd_req[p]  = 1'b1;
        bus.rd_addr[p] = a;
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic do_reset();
        next_cycle();
        reset = 1'b1;
        clr_inputs();
        next_cycle();
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int re_start;

    initial begin
        reset       = 1'b1;
        bus.wb_valid = '0;
        bus.wb_addr  = '0;
        bus.wb_data  = '0;
        bus.rd_req   = '0;
        bus.rd_addr  = '0;
        do_reset();

        // Reset state
        sample();
        check("rst_count", 64'(dbg_count), 64'(0));
        check("rst_stall", 64'(bus.wb_stall), 64'(0));
        check("rst_rd_valid", 64'(bus.rd_valid), 64'(0));
        check("rst_mem_re", 64'(bus.mem_re), 64'(0));
        check("rst_mem_we", 64'(bus.mem_we), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));

        // Four simultaneous writes drain in index order
        next_cycle(); clr_inputs();
        for (int k = 0; k < 4; k++) begin
            set_wb(k, AW'(k + 1), DW'(32'h11 * (k + 1)));
            push_exp(AW'(k + 1), DW'(32'h11 * (k + 1)));
        end
        sample();
        check("t1_we_first", 64'(bus.mem_we), 64'(0));
        for (int c = 0; c < 4; c++) begin
            next_cycle(); clr_inputs();
            sample();
            check("t1_we", 64'(bus.mem_we), 64'(1));
            check("t1_waddr", 64'(bus.mem_addr), 64'(c + 1));
            check("t1_count", 64'(dbg_count), 64'(4 - c));
        end
        next_cycle(); sample();
        check("t1_count_end", 64'(dbg_count), 64'(0));
        check("t1_we_end", 64'(bus.mem_we), 64'(0));

        // Forwarding hit: write addr 5, read it the next cycle
        re_start = re_cnt;
        next_cycle(); clr_inputs();
        set_wb(WB_C0_CPU, 4'd5, 32'hAAAA);
        push_exp(4'd5, 32'hAAAA);
        next_cycle(); clr_inputs();
        set_rd(1, 4'd5);
        sample();
        check("t2_re_grant", 64'(bus.mem_re), 64'(0));
        check("t2_we_grant", 64'(bus.mem_we), 64'(0));
        next_cycle(); sample();
        check("t2_rd_valid", 64'(bus.rd_valid), 64'(2'b10));
        check("t2_rd_data", 64'(bus.rd_data), 64'(32'hAAAA));
        check("t2_we_drain", 64'(bus.mem_we), 64'(1));
        next_cycle(); clr_inputs(); sample();
        check("t2_rd_valid_off", 64'(bus.rd_valid), 64'(0));
        check("t2_no_mem_re", 64'(re_cnt - re_start), 64'(0));

        // Contention: port 0 first, then port 1
        next_cycle(); clr_inputs();
        set_rd(0, 4'd7); set_rd(1, 4'd8);
        sample();
        check("t4_re0", 64'(bus.mem_re), 64'(1));
        check("t4_addr0", 64'(bus.mem_addr), 64'(7));
        next_cycle(); sample();
        check("t4_state_wait", 64'(dbg_state), 64'(ST_RD_WAIT));
        check("t4_rv0", 64'(bus.rd_valid), 64'(2'b01));
        check("t4_rd0", 64'(bus.rd_data), 64'(32'hC0DE_0007));
        check("t4_re_wait", 64'(bus.mem_re), 64'(0));
        next_cycle(); clr_inputs();
        set_rd(1, 4'd8);
        sample();
        check("t4_re1", 64'(bus.mem_re), 64'(1));
        check("t4_addr1", 64'(bus.mem_addr), 64'(8));
        next_cycle(); sample();
        check("t4_rv1", 64'(bus.rd_valid), 64'(2'b10));
        check("t4_rd1", 64'(bus.rd_data), 64'(32'hC0DE_0008));
        // Port 0 alone, then a contention that port 1 must win
        next_cycle(); clr_inputs();
        set_rd(0, 4'd9);
        sample();
        check("t4_addr_solo", 64'(bus.mem_addr), 64'(9));
        next_cycle(); sample();
        check("t4_rv_solo", 64'(bus.rd_valid), 64'(2'b01));
        next_cycle(); clr_inputs();
        next_cycle(); clr_inputs();
        set_rd(0, 4'd9); set_rd(1, 4'd10);
        sample();
        check("t4_rr_re", 64'(bus.mem_re), 64'(1));
        check("t4_rr_addr", 64'(bus.mem_addr), 64'(10));
        next_cycle(); sample();
        check("t4_rr_rv", 64'(bus.rd_valid), 64'(2'b10));
        check("t4_rr_rd", 64'(bus.rd_data), 64'(32'hC0DE_000A));
        next_cycle(); clr_inputs();
        set_rd(0, 4'd9);
        sample();
        check("t4_p0_addr", 64'(bus.mem_addr), 64'(9));
        next_cycle(); sample();
        check("t4_p0_rd", 64'(bus.rd_data), 64'(32'hC0DE_0009));
        next_cycle(); clr_inputs();

        // Same-address duplicates in one cycle: youngest forwarded and last written
        next_cycle(); clr_inputs();
        set_wb(WB_C0_CPU, 4'd3, 32'd1);
        set_wb(WB_C1_CPU, 4'd3, 32'd2);
        push_exp(4'd3, 32'd1);
        push_exp(4'd3, 32'd2);
        next_cycle(); clr_inputs();
        set_rd(0, 4'd3);
        sample();
        check("t3_re", 64'(bus.mem_re), 64'(0));
        next_cycle(); sample();
        check("t3_rv", 64'(bus.rd_valid), 64'(2'b01));
        check("t3_rd", 64'(bus.rd_data), 64'(2));
        next_cycle(); clr_inputs(); sample();
        check("t3_we2", 64'(bus.mem_we), 64'(1));
        next_cycle(); sample();
        check("t3_count", 64'(dbg_count), 64'(0));
        check("t3_mem3", 64'(mem_model[3]), 64'(2));

        // Stall at full buffer; a pending miss waits for a drain
        do_reset();
        next_cycle(); clr_inputs();
        for (int k = 0; k < 4; k++) begin
            set_wb(k, AW'(8 + k), DW'(32'hD0 + k));
            push_exp(AW'(8 + k), DW'(32'hD0 + k));
        end
        sample();
        check("t5_stall_a", 64'(bus.wb_stall), 64'(0));
        next_cycle(); clr_inputs();
        for (int k = 0; k < 4; k++) begin
            set_wb(k, AW'(12 + k), DW'(32'hE0 + k));
            push_exp(AW'(12 + k), DW'(32'hE0 + k));
        end
        set_rd(0, 4'd9);
        sample();
        check("t5_stall_b", 64'(bus.wb_stall), 64'(0));
        check("t5_we_b", 64'(bus.mem_we), 64'(0));
        check("t5_re_b", 64'(bus.mem_re), 64'(0));
        next_cycle(); clr_inputs();
        for (int k = 0; k < 4; k++) set_wb(k, AW'(k), 32'hFF);
        set_rd(0, 4'd9); set_rd(1, 4'd7);
        sample();
        check("t5_stall_c", 64'(bus.wb_stall), 64'(1));
        check("t5_count_c", 64'(dbg_count), 64'(8));
        check("t5_rv_c", 64'(bus.rd_valid), 64'(2'b01));
        check("t5_rd_c", 64'(bus.rd_data), 64'(32'hD1));
        check("t5_re_c", 64'(bus.mem_re), 64'(0));
        check("t5_we_c", 64'(bus.mem_we), 64'(1));
        next_cycle(); clr_inputs();
        for (int k = 0; k < 4; k++) set_wb(k, AW'(k), 32'hFF);
        set_rd(1, 4'd7);
        sample();
        check("t5_count_d", 64'(dbg_count), 64'(7));
        check("t5_stall_d", 64'(bus.wb_stall), 64'(1));
        check("t5_re_d", 64'(bus.mem_re), 64'(1));
        check("t5_addr_d", 64'(bus.mem_addr), 64'(7));
        next_cycle(); clr_inputs();
        set_rd(1, 4'd7);
        sample();
        check("t5_rv_e", 64'(bus.rd_valid), 64'(2'b10));
        check("t5_rd_e", 64'(bus.rd_data), 64'(32'hC0DE_0007));
        check("t5_count_e", 64'(dbg_count), 64'(7));
        for (int c = 0; c < 8; c++) begin
            next_cycle(); clr_inputs();
        end
        sample();
        check("t5_count_end", 64'(dbg_count), 64'(0));
        check("t5_stall_end", 64'(bus.wb_stall), 64'(0));
        check("t5_mem0", 64'(mem_model[0]), 64'(32'hC0DE_0000));
        check("t5_exp_q", 64'(exp_q.size()), 64'(0));

        // Reset during RD_WAIT with three entries buffered
        next_cycle(); clr_inputs();
        for (int k = 0; k < 3; k++) set_wb(k, AW'(1 + k), DW'(32'h51 + k));
        set_rd(0, 4'd6);
        sample();
        check("t6_re", 64'(bus.mem_re), 64'(1));
        next_cycle(); clr_inputs();
        reset = 1'b1;
        sample();
        check("t6_rv_rst", 64'(bus.rd_valid), 64'(0));
        check("t6_we_rst", 64'(bus.mem_we), 64'(0));
        next_cycle();
        reset = 1'b0;
        sample();
        check("t6_count", 64'(dbg_count), 64'(0));
        check("t6_stall", 64'(bus.wb_stall), 64'(0));
        check("t6_rv", 64'(bus.rd_valid), 64'(0));
        check("t6_we", 64'(bus.mem_we), 64'(0));
        check("t6_state", 64'(dbg_state), 64'(ST_IDLE));
        next_cycle(); sample();
        check("t6_we_after", 64'(bus.mem_we), 64'(0));
        check("t6_exp_q", 64'(exp_q.size()), 64'(0));

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
